// File: rtl/csr_commit_ctrl_pkg.sv
// Shared constants and types for the SYSTEM-instruction commit controller.
// Holds CSR addresses, SYSTEM opcode fields, and the FSM and decoded-op enums.
package csr_commit_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hf11;
  localparam logic [11:0] CSR_MARCHID   = 12'hf12;

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0]  F3_PRIV    = 3'b000;
  localparam logic [2:0]  F3_CSRRW   = 3'b001;
  localparam logic [2:0]  F3_CSRRS   = 3'b010;
  localparam logic [11:0] IMM_ECALL  = 12'h000;
  localparam logic [11:0] IMM_MRET   = 12'h302;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_ISSUE, S_SETTLE, S_DONE} state_e;
  typedef enum logic [2:0] {OP_CSRRW, OP_CSRRS, OP_ECALL, OP_MRET, OP_ILLEGAL} op_e;
endpackage

// File: rtl/csr_sys_decode.sv
// Combinational SYSTEM-instruction decode: classifies the op and extracts rd
// and the CSR address field.
module csr_sys_decode
  import csr_commit_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output op_e         op_o,
  output logic [4:0]  rd_o,
  output logic [11:0] addr_o
);
  // rs1 index is carried by the WBU as a value, so the field is not decoded here.
  logic unused_rs1;
  assign unused_rs1 = ^inst_i[19:15];

  assign rd_o   = inst_i[11:7];
  assign addr_o = inst_i[31:20];

  always_comb begin
    op_o = OP_ILLEGAL;
    if (inst_i[6:0] == OPC_SYSTEM) begin
      case (inst_i[14:12])
        F3_CSRRW: op_o = OP_CSRRW;
        F3_CSRRS: op_o = OP_CSRRS;
        F3_PRIV: begin
          if (inst_i[31:20] == IMM_ECALL)     op_o = OP_ECALL;
          else if (inst_i[31:20] == IMM_MRET) op_o = OP_MRET;
        end
        default: op_o = OP_ILLEGAL;
      endcase
    end
  end
endmodule

// File: rtl/csr_commit_ctrl.sv
// Sequences CSRRW/CSRRS/ECALL/MRET from write-back into the CSR file:
// read old value, issue one write request, wait out the write, report rd and next PC.
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] RESET_VEC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_rdata,
  output logic        csr_valid,
  input  logic        csr_ready,
  output logic [31:0] csr_wdata,
  output logic [31:0] csr_inst,
  output logic [31:0] csr_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        done_valid,
  input  logic        done_ready,
  output logic        rd_wen,
  output logic [4:0]  rd_idx,
  output logic [31:0] rd_data,
  output logic [31:0] next_pc,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e      state_q, state_d;
  op_e         op_q, dec_op;
  logic [4:0]  rd_q, dec_rd;
  logic [11:0] addr_q, dec_addr;
  logic [31:0] inst_q, pc_q, rs1_q, old_q, trap_q, wdata_q, next_pc_q;
  logic [CW-1:0] cnt_q;
  logic        err_q;
  logic        timeout;

  // Decode the incoming word so ILLEGAL can skip straight to DONE on accept.
  csr_sys_decode u_dec (
    .inst_i (in_inst),
    .op_o   (dec_op),
    .rd_o   (dec_rd),
    .addr_o (dec_addr)
  );

  assign timeout = !csr_ready && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = (dec_op == OP_ILLEGAL) ? S_DONE : S_READ;
      S_READ:   state_d = S_ISSUE;
      S_ISSUE:  if (csr_ready) state_d = S_SETTLE;
                else if (timeout) state_d = S_DONE;
      S_SETTLE: state_d = S_DONE;
      S_DONE:   if (done_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ILLEGAL;
      rd_q      <= '0;
      addr_q    <= '0;
      inst_q    <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      old_q     <= '0;
      trap_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      next_pc_q <= RESET_VEC;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          inst_q <= in_inst;
          pc_q   <= in_pc;
          rs1_q  <= in_rs1;
          op_q   <= dec_op;
          rd_q   <= dec_rd;
          addr_q <= dec_addr;
          old_q  <= '0;
          cnt_q  <= '0;
          err_q  <= (dec_op == OP_ILLEGAL);
          if (dec_op == OP_ILLEGAL) next_pc_q <= in_pc + 32'd4;
        end
        S_READ: begin
          old_q <= csr_rdata;
          case (op_q)
            OP_ECALL: trap_q <= mtvec;
            OP_MRET:  trap_q <= mepc;
            default:  trap_q <= pc_q + 32'd4;
          endcase
          case (op_q)
            OP_CSRRW: wdata_q <= rs1_q;
            OP_CSRRS: wdata_q <= csr_rdata | rs1_q;
            default:  wdata_q <= '0;
          endcase
        end
        S_ISSUE: begin
          cnt_q <= cnt_q + CW'(1);
          if (timeout) begin
            err_q     <= 1'b1;
            next_pc_q <= trap_q;
          end
        end
        S_SETTLE: next_pc_q <= trap_q;
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign csr_addr   = (state_q == S_READ) ? addr_q : '0;
  assign csr_valid  = (state_q == S_ISSUE);
  assign csr_wdata  = csr_valid ? wdata_q : '0;
  assign csr_inst   = csr_valid ? inst_q : '0;
  assign csr_pc     = csr_valid ? pc_q : '0;
  assign done_valid = (state_q == S_DONE);
  assign rd_wen     = done_valid && !err_q && (rd_q != 5'd0) &&
                      (op_q == OP_CSRRW || op_q == OP_CSRRS);
  assign rd_idx     = done_valid ? rd_q : '0;
  assign rd_data    = done_valid ? old_q : '0;
  assign err        = done_valid && err_q;
  assign next_pc    = next_pc_q;
endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Randomized bench for csr_commit_ctrl: per-transaction timeline model derived
// from the instruction semantics and the stall pattern chosen for that transaction.
module tb_csr_commit_ctrl;
  import csr_commit_ctrl_pkg::*;
  localparam int          TIMEOUT   = 16;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;

  logic clk = 1'b0, rst_n;
  logic in_valid, in_ready, csr_valid, csr_ready, done_valid, done_ready, rd_wen, err;
  logic [31:0] in_inst, in_pc, in_rs1, csr_rdata, csr_wdata, csr_inst, csr_pc;
  logic [31:0] mtvec, mepc, rd_data, next_pc;
  logic [11:0] csr_addr;
  logic [4:0]  rd_idx;

  csr_commit_ctrl #(.TIMEOUT(TIMEOUT), .RESET_VEC(RESET_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1), .csr_addr(csr_addr),
    .csr_rdata(csr_rdata), .csr_valid(csr_valid), .csr_ready(csr_ready),
    .csr_wdata(csr_wdata), .csr_inst(csr_inst), .csr_pc(csr_pc), .mtvec(mtvec),
    .mepc(mepc), .done_valid(done_valid), .done_ready(done_ready), .rd_wen(rd_wen),
    .rd_idx(rd_idx), .rd_data(rd_data), .next_pc(next_pc), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] exp_npc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [11:0] imm, input logic [4:0] rs1i,
                                     input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] opc);
    return {imm, rs1i, f3, rd, opc};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  // k = ISSUE cycles with csr_ready low, d = DONE cycles with done_ready low.
  task automatic run_txn(input logic [31:0] inst, pc, rs1, old, tv, ep, input int k, d);
    int kind, done_t, iss_end;
    bit tmo, ill, wen;
    logic [31:0] wd, npc;
    kind = 4;
    if (inst[6:0] == 7'h73) begin
      if (inst[14:12] == 3'd1) kind = 0;
      else if (inst[14:12] == 3'd2) kind = 1;
      else if (inst[14:12] == 3'd0 && inst[31:20] == 12'h000) kind = 2;
      else if (inst[14:12] == 3'd0 && inst[31:20] == 12'h302) kind = 3;
    end
    ill = (kind == 4);
    tmo = !ill && (k >= TIMEOUT);
    wd  = (kind == 0) ? rs1 : (kind == 1) ? (old | rs1) : 32'h0;
    npc = (kind == 2) ? tv : (kind == 3) ? ep : pc + 32'd4;
    wen = (kind <= 1) && (inst[11:7] != 5'd0) && !tmo;
    done_t  = ill ? 1 : tmo ? 2 + TIMEOUT : 4 + k;
    iss_end = tmo ? 2 + TIMEOUT : 3 + k;

    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_rs1 = rs1;
    csr_rdata = old; mtvec = tv; mepc = ep; csr_ready = 1'b0; done_ready = 1'b0;
    @(posedge clk);
    for (int t = 1; t <= done_t + d + 1; t++) begin
      @(negedge clk);
      in_valid = 1'b0; in_inst = $urandom; in_pc = $urandom; in_rs1 = $urandom;
      if (t >= 2) begin
        csr_rdata = $urandom; mtvec = $urandom; mepc = $urandom;
      end
      csr_ready  = (t >= 2 + k);
      done_ready = (t >= done_t + d);
      if (t == 1 && !ill) chk("csr_addr", {20'b0, csr_addr}, {20'b0, inst[31:20]});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (t == done_t + d + 1)});
      chk("done_valid", {31'b0, done_valid}, {31'b0, (t >= done_t && t <= done_t + d)});
      chk("csr_valid", {31'b0, csr_valid}, {31'b0, (!ill && t >= 2 && t < iss_end)});
      chk("next_pc", next_pc, (t >= done_t) ? npc : exp_npc);
      if (!ill && t >= 2 && t < iss_end) begin
        chk("csr_wdata", csr_wdata, wd);
        chk("csr_inst", csr_inst, inst);
        chk("csr_pc", csr_pc, pc);
      end
      if (t >= done_t && t <= done_t + d) begin
        chk("err", {31'b0, err}, {31'b0, (ill || tmo)});
        chk("rd_wen", {31'b0, rd_wen}, {31'b0, wen});
        chk("rd_idx", {27'b0, rd_idx}, {27'b0, inst[11:7]});
        if (!ill) chk("rd_data", rd_data, old);
      end
    end
    exp_npc = npc;
  endtask

  initial begin
    logic [11:0] csrs [6];
    logic [31:0] inst, pc;
    logic [11:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    int cat, k, d;
    csrs = '{CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MVENDORID, CSR_MARCHID};
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_rs1 = '0;
    csr_rdata = '0; csr_ready = 1'b0; mtvec = '0; mepc = '0; done_ready = 1'b0;
    exp_npc = RESET_VEC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_next_pc", next_pc, RESET_VEC);
    chk("rst_done_valid", {31'b0, done_valid}, 32'd0);
    chk("rst_csr_valid", {31'b0, csr_valid}, 32'd0);
    chk("rst_rd_wen_err", {30'b0, rd_wen, err}, 32'd0);
    rst_n = 1'b1;

    run_txn(mk(CSR_MTVEC, 5'd1, F3_CSRRW, 5'd5, OPC_SYSTEM), 32'h8000_0000,
            32'h8000_0100, 32'h0, 32'h0, 32'h0, 0, 0);
    run_txn(mk(CSR_MSTATUS, 5'd2, F3_CSRRS, 5'd6, OPC_SYSTEM), 32'h8000_0004,
            32'h8, 32'h1800, 32'h0, 32'h0, 0, 0);
    run_txn(mk(IMM_ECALL, 5'd0, F3_PRIV, 5'd0, OPC_SYSTEM), 32'h8000_0040,
            32'h0, 32'h0, 32'h8000_0200, 32'h0, 0, 0);
    run_txn(mk(IMM_MRET, 5'd0, F3_PRIV, 5'd0, OPC_SYSTEM), 32'h8000_0200,
            32'h0, 32'h0, 32'h8000_0200, 32'h8000_0040, 0, 0);
    run_txn(mk(CSR_MEPC, 5'd3, F3_CSRRW, 5'd7, OPC_SYSTEM), 32'h8000_0100,
            32'h1234, 32'h55, 32'h0, 32'h0, 3, 0);
    run_txn(mk(CSR_MCAUSE, 5'd3, F3_CSRRS, 5'd9, OPC_SYSTEM), 32'h8000_0110,
            32'h1, 32'h2, 32'h0, 32'h0, TIMEOUT, 0);
    run_txn(mk(CSR_MSTATUS, 5'd0, F3_CSRRS, 5'd8, OPC_SYSTEM), 32'h8000_0120,
            32'h0, 32'hA5, 32'h0, 32'h0, 0, 4);
    run_txn(mk(12'h000, 5'd0, 3'b100, 5'd4, OPC_SYSTEM), 32'h8000_0130,
            32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    run_txn(mk(CSR_MARCHID, 5'd1, F3_CSRRW, 5'd0, OPC_SYSTEM), 32'hFFFF_FFFC,
            32'h9, 32'h7, 32'h0, 32'h0, 0, 0);

    // Reset while the request is outstanding in ISSUE.
    in_valid = 1'b1; in_inst = mk(CSR_MTVEC, 5'd1, F3_CSRRW, 5'd5, OPC_SYSTEM);
    in_pc = 32'h8000_0300; csr_ready = 1'b0; done_ready = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("rst_issue_csr_valid", {31'b0, csr_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_next_pc", next_pc, RESET_VEC);
    chk("rst_mid_done_valid", {31'b0, done_valid}, 32'd0);
    chk("rst_mid_csr_valid", {31'b0, csr_valid}, 32'd0);
    rst_n = 1'b1;
    exp_npc = RESET_VEC;

    for (int n = 0; n < 150; n++) begin
      cat = $urandom_range(0, 5);
      imm = csrs[$urandom_range(0, 5)];
      case (cat)
        0: inst = mk(imm, 5'($urandom), F3_CSRRW, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), OPC_SYSTEM);
        1: inst = mk(imm, 5'($urandom), F3_CSRRS, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), OPC_SYSTEM);
        2: inst = mk(IMM_ECALL, 5'($urandom), F3_PRIV, 5'($urandom), OPC_SYSTEM);
        3: inst = mk(IMM_MRET, 5'($urandom), F3_PRIV, 5'($urandom), OPC_SYSTEM);
        4: begin
          f3 = 3'($urandom_range(3, 7));
          if ($urandom_range(0, 1) == 0) begin
            f3 = F3_PRIV;
            imm = 12'($urandom_range(1, 4095));
            if (imm == IMM_MRET) imm = 12'h303;
          end
          inst = mk(imm, 5'($urandom), f3, 5'($urandom), OPC_SYSTEM);
        end
        default: begin
          opc = 7'($urandom);
          if (opc == OPC_SYSTEM) opc = 7'h33;
          inst = mk(imm, 5'($urandom), F3_CSRRW, 5'($urandom), opc);
        end
      endcase
      pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
      k = ($urandom_range(0, 7) == 0) ? TIMEOUT + $urandom_range(0, 2) : $urandom_range(0, 5);
      d = $urandom_range(0, 3);
      run_txn(inst, pc, $urandom, $urandom, $urandom, $urandom, k, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
